aes_key_sched_ctrl: RTL
=======================

# aes_key_sched_ctrl

Sequencer and storage for the AES-128 key schedule. It accepts a 128-bit cipher key, drives the combinational `sub_keyexpansion` step once per clock for rounds 1..10, and stores all 11 round keys in a register file. The cipher core then reads round keys by index through a registered read port. It sits between the key-load interface and the round datapath.

## Interface
- `NUM_RK`, default 11: round keys stored (index 0..10). Fixed for AES-128.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `key_valid`  in  1  cipher key offered.
- `key_in`  in  128  cipher key; byte 0 = bits [127:120].
- `key_ready`  out  1  controller can accept a key.
- `sched_done`  out  1  all 11 round keys stored and valid.
- `rk_rd_en`  in  1  round-key read request.
- `rk_idx`  in  4  round-key index.
- `rk_out`  out  128  round key read data.
- `rk_out_vld`  out  1  `rk_out` holds a valid key for the previous request.

## Operation
- FSM states and transitions:
  - IDLE -> EXPAND when `key_valid && key_ready`. Writes `key_in` to rk[0] and the working register. Sets `iter` = 1.
  - EXPAND, one step per cycle: `sub_keyexpansion(in=work, iter)` result goes to rk[iter] and to work; `iter` increments. When `iter`==10 is written, -> READY.
  - READY: a handshake (`key_valid && key_ready`) restarts exactly as from IDLE.
- `key_ready` = 1 in IDLE and READY, 0 in EXPAND. `key_valid` during EXPAND is ignored and does not stall or queue.
- `sched_done` = 1 only in READY. It drops the cycle after a new key is accepted.
- `iter` is 8 bits, zero-extended from a 4-bit counter. RCON maps 1..10 to 01,02,04,08,10,20,40,80,1B,36.
- Read port:
  - On `rk_rd_en`, the next cycle shows `rk_out` = rk[rk_idx].
  - `rk_out_vld` = 1 only if `rk_idx` <= 10 and that entry has been written for the current key.
  - Otherwise `rk_out` = 0 and `rk_out_vld` = 0.
  - Reads are allowed in every state. rk[0] is readable the cycle after acceptance.
  - When `rk_rd_en` = 0, `rk_out` holds its value and `rk_out_vld` = 0.
- Per-entry written flags (11 bits) clear on key acceptance. Each flag sets when its entry is written.
- Read and write to the same index in the same cycle: the read returns the old contents, with the old flag.

## Timing
- Reset values: `key_ready`=1, `sched_done`=0, `rk_out`=0, `rk_out_vld`=0. FSM = IDLE, `iter`=0, flags=0. Register-file contents are don't-care.
- Latency, with key accepted at edge 0: rk[0] written at edge 0, rk[n] written at edge n, `sched_done` high after edge 10.
- Throughput: one key per 11 cycles, back-to-back.
- Asserting `rst` mid-EXPAND aborts immediately. All outputs return to reset values; a partial schedule is never flagged valid.

## Configuration
- `KEY_SCHED_REV_EN`:
  - Defined: adds input `rk_rev` (1 bit), sampled with `rk_rd_en`. The effective index becomes 10 − `rk_idx`, so the decryption core can read keys in forward order. The range check (`rk_idx` <= 10) is applied to `rk_idx` before remapping.
  - Undefined: port absent; indexing is direct.

## Structure
- Shared package `aes_pkg` holds `AES_NUM_RK`=11, `AES_LAST_ROUND`=10, `rk_t` (128-bit round-key type) and the FSM state enum (IDLE, EXPAND, READY).
- One sub-module: `sub_keyexpansion`, instantiated once and combinational. No other sub-modules; the register file and flags are inline.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c:
  - rk[1] = a0fafe1788542cb123a339392a6c7605
  - rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6
  - `sched_done` rises exactly 10 cycles after acceptance.
- Read during EXPAND: read rk_idx=5 at cycle 3 -> `rk_out_vld`=0, `rk_out`=0. Read rk_idx=2 at cycle 3 -> valid and equal to the FIPS value.
- `key_valid` held during EXPAND with a second key -> ignored. Schedule matches the first key; second key accepted only once `key_ready`=1.
- `rst` pulsed at cycle 5 of EXPAND -> all outputs at reset values. Read rk_idx=3 -> `rk_out_vld`=0.
- `rk_idx`=11 and `rk_idx`=15 in READY -> `rk_out_vld`=0, `rk_out`=0.
- With `KEY_SCHED_REV_EN`: `rk_rev`=1, `rk_idx`=0 -> rk[10] = d014f9a8…0ca6, valid.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule constants, round-key type, sequencer states and RCON lookup.
package aes_pkg;

    localparam int AES_NUM_RK     = 11;
    localparam int AES_LAST_ROUND = 10;

    typedef logic [127:0] rk_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_t;

    function automatic logic [7:0] rcon(input logic [7:0] iter);
        logic [7:0] r;
        case (iter)
            8'd1:    r = 8'h01;
            8'd2:    r = 8'h02;
            8'd3:    r = 8'h04;
            8'd4:    r = 8'h08;
            8'd5:    r = 8'h10;
            8'd6:    r = 8'h20;
            8'd7:    r = 8'h40;
            8'd8:    r = 8'h80;
            8'd9:    r = 8'h1b;
            8'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sub_keyexpansion.sv
// One combinational AES-128 key-expansion step: round key (iter-1) -> round key iter.
module sub_keyexpansion
    import aes_pkg::*;
(
    input  rk_t        key_in,
    input  logic [7:0] iter,
    output rk_t        key_out
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box computed as GF(2^8) inverse (a^254) followed by the affine map, instead of a 256-entry table.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] base;
        r    = 8'h01;
        base = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gf_mul(r, base);
            base = gf_mul(base, base);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    logic [31:0] w0, w1, w2, w3, rot, temp, n0, n1, n2, n3;

    always_comb begin
        w0   = key_in[127:96];
        w1   = key_in[95:64];
        w2   = key_in[63:32];
        w3   = key_in[31:0];
        rot  = {w3[23:0], w3[31:24]};
        temp = {sbox(rot[31:24]) ^ rcon(iter), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        n0   = w0 ^ temp;
        n1   = w1 ^ n0;
        n2   = w2 ^ n1;
        n3   = w3 ^ n2;
    end

    assign key_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule sequencer with 11-entry round-key store and registered read port.
// Optional KEY_SCHED_REV_EN adds rk_rev for reversed (10 - rk_idx) indexing.
//   state  | meaning
//   IDLE   | no schedule held, waiting for a key
//   EXPAND | generating rk[1..10], one per cycle
//   READY  | full schedule valid, new key may restart
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_RK = AES_NUM_RK
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [127:0] key_in,
    output logic         key_ready,
    output logic         sched_done,
    input  logic         rk_rd_en,
`ifdef KEY_SCHED_REV_EN
    input  logic         rk_rev,
`endif
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_out,
    output logic         rk_out_vld
);

    state_t            state, next_state;
    logic [3:0]        iter_cnt;
    logic [7:0]        iter;
    logic              accept, step, last_step;
    rk_t               work, exp_out;
    rk_t               rk [NUM_RK];
    logic [NUM_RK-1:0] written;
    logic [3:0]        eff_idx;
    logic              in_range, hit;

    assign iter      = {4'b0000, iter_cnt};
    assign last_step = (iter_cnt == 4'(AES_LAST_ROUND));

    sub_keyexpansion u_sub_keyexpansion (
        .key_in  (work),
        .iter    (iter),
        .key_out (exp_out)
    );

    always_comb begin
        next_state = state;
        key_ready  = 1'b0;
        sched_done = 1'b0;
        accept     = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                key_ready = 1'b1;
                if (key_valid) begin
                    accept     = 1'b1;
                    next_state = EXPAND;
                end
            end
            EXPAND: begin
                step = 1'b1;
                if (last_step) next_state = READY;
            end
            READY: begin
                key_ready  = 1'b1;
                sched_done = 1'b1;
                if (key_valid) begin
                    accept     = 1'b1;
                    next_state = EXPAND;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            iter_cnt <= 4'd0;
            written  <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                iter_cnt <= 4'd1;
                written  <= {{(NUM_RK-1){1'b0}}, 1'b1};
            end else if (step) begin
                iter_cnt          <= last_step ? 4'd0 : iter_cnt + 4'd1;
                written[iter_cnt] <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the written flags alone decide what is readable.
    always_ff @(posedge clk) begin
        if (accept) begin
            work  <= key_in;
            rk[0] <= key_in;
        end else if (step) begin
            work         <= exp_out;
            rk[iter_cnt] <= exp_out;
        end
    end

    // Range check uses the raw index, before any reversal.
    always_comb begin
`ifdef KEY_SCHED_REV_EN
        eff_idx = rk_rev ? 4'(AES_LAST_ROUND) - rk_idx : rk_idx;
`else
        eff_idx = rk_idx;
`endif
        in_range = (rk_idx <= 4'(AES_LAST_ROUND));
        hit      = 1'b0;
        if (in_range) hit = written[eff_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rk_out     <= '0;
            rk_out_vld <= 1'b0;
        end else begin
            rk_out_vld <= rk_rd_en && hit;
            if (rk_rd_en) rk_out <= hit ? rk[eff_idx] : '0;
        end
    end

endmodule
